// File: rtl/edge_acc_pkg.sv
// ---------------------------------------------------------------------------
// edge_acc_pkg
// Shared types and constants for the edge-mask accumulator:
//   - acc_state_e  : frame assembly FSM states (IDLE / FILL / COMMIT)
//   - merge_mode_e : accumulator merge modes (OR / AND / overwrite)
//   - FRAME_CNT_W  : width of the merged-frame counter
// ---------------------------------------------------------------------------
package edge_acc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } acc_state_e;

  // Encoding 2'd3 is reserved and is treated as OR by the merge logic.
  typedef enum logic [1:0] {
    MODE_OR  = 2'd0,
    MODE_AND = 2'd1,
    MODE_OVR = 2'd2
  } merge_mode_e;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/edge_word_mux.sv
// ---------------------------------------------------------------------------
// edge_word_mux
// Registered WORD_W-bit read multiplexer over a flat WORDS*WORD_W vector.
// Addresses at or beyond WORDS return zero but still raise rd_valid_o.
// Ports:
//   clk_i      clock (rising edge)
//   rst_i      synchronous active-high reset
//   rd_en_i    read request
//   rd_addr_i  word index
//   data_i     flat source vector, word w at [w*WORD_W +: WORD_W]
//   rd_data_o  registered read data (held when no read is issued)
//   rd_valid_o registered; 1 exactly one cycle after rd_en_i
// ---------------------------------------------------------------------------
module edge_word_mux #(
  parameter int  WORD_W = 32,
  parameter int  WORDS  = 64,
  localparam int AW     = $clog2(WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rd_en_i,
  input  logic [AW-1:0]           rd_addr_i,
  input  logic [WORD_W*WORDS-1:0] data_i,
  output logic [WORD_W-1:0]       rd_data_o,
  output logic                    rd_valid_o
);

  logic [WORD_W-1:0] rd_data_q;
  logic [WORD_W-1:0] rd_data_d;
  logic              rd_valid_q;

  // AND-OR select: no word matches an out-of-range address, so it reads zero.
  always_comb begin
    rd_data_d = '0;
    for (int w = 0; w < WORDS; w++) begin
      rd_data_d = rd_data_d |
                  ({WORD_W{rd_addr_i == AW'(w)}} & data_i[w*WORD_W +: WORD_W]);
    end
  end

  // Output register: capture on a read, flag validity for one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_en_i) begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= 1'b1;
    end else begin
      rd_data_q  <= rd_data_q;
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/edge_accum_v2_0.sv
// ---------------------------------------------------------------------------
// edge_accum_v2_0
// Assembles BEATS beats of BEAT_W-bit edge masks into a frame under a
// valid/ready handshake, merges the complete frame into a persistent
// accumulator in a one-cycle COMMIT state, and exposes the accumulator as
// WORD_W-bit words over a registered read port.
// Optional feature macro: EDGE_ACC_MODE_EN
//   defined   : 'mode' port selects OR / AND / overwrite (3 acts as OR),
//               sampled in the COMMIT cycle
//   undefined : no 'mode' port, merge is always OR
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   clr         synchronous clear of accumulator, frame, counters (top priority)
//   in_valid    beat presented      in_ready   beat accepted this cycle
//   edge_mask   beat data           mode       merge mode (optional)
//   beat_idx    next beat index     frame_done one-cycle merge pulse
//   frame_cnt   merged frames (wraps)
//   rd_en/rd_addr -> rd_data/rd_valid one cycle later
// ---------------------------------------------------------------------------
module edge_accum_v2_0 import edge_acc_pkg::*; #(
  parameter int  BEAT_W  = 128,
  parameter int  BEATS   = 16,
  parameter int  WORD_W  = 32,
  localparam int TOTAL_W = BEAT_W * BEATS,
  localparam int WORDS   = TOTAL_W / WORD_W,
  localparam int AW      = $clog2(WORDS),
  localparam int BW      = $clog2(BEATS)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BEAT_W-1:0]      edge_mask,
`ifdef EDGE_ACC_MODE_EN
  input  logic [1:0]             mode,
`endif
  output logic [BW-1:0]          beat_idx,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [WORD_W-1:0]      rd_data,
  output logic                   rd_valid
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  acc_state_e             state_q, state_d;
  logic                   rdy_q, rdy_d;
  logic [BW-1:0]          beat_idx_q, beat_idx_d;
  logic [TOTAL_W-1:0]     frame_q, frame_d;
  logic [TOTAL_W-1:0]     acc_q, acc_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   accept_s;
  logic                   commit_s;
  logic [1:0]             mode_s;

`ifdef EDGE_ACC_MODE_EN
  assign mode_s = mode;
`else
  assign mode_s = MODE_OR;
`endif

  function automatic logic [TOTAL_W-1:0] merge_f(
    input logic [1:0]         m,
    input logic [TOTAL_W-1:0] acc,
    input logic [TOTAL_W-1:0] frm
  );
    logic [TOTAL_W-1:0] res;
    case (m)
      MODE_AND: res = acc & frm;
      MODE_OVR: res = frm;
      default:  res = acc | frm;
    endcase
    return res;
  endfunction

  // rdy_q carries the FSM's registered ready; RST and clr mask it in-cycle so
  // no beat slips in while the block is being reset or cleared.
  assign in_ready   = rdy_q & ~RST & ~clr;
  assign accept_s   = in_valid & in_ready;
  // A clr landing in COMMIT aborts the merge, so it also suppresses the pulse.
  assign commit_s   = (state_q == COMMIT) & ~clr;
  assign frame_done = commit_s;
  assign beat_idx   = beat_idx_q;
  assign frame_cnt  = cnt_q;

  // Next-state logic for FSM, beat index, frame buffer, accumulator, counter.
  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    frame_d    = frame_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    if (clr) begin
      state_d    = IDLE;
      beat_idx_d = '0;
      frame_d    = '0;
      acc_d      = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        IDLE:    state_d = accept_s ? FILL : IDLE;
        FILL:    state_d = (accept_s && (beat_idx_q == LAST_BEAT)) ? COMMIT : FILL;
        COMMIT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (accept_s) begin
        beat_idx_d = (beat_idx_q == LAST_BEAT) ? '0 : (beat_idx_q + BW'(1));
        for (int b = 0; b < BEATS; b++) begin
          frame_d[b*BEAT_W +: BEAT_W] = (beat_idx_q == BW'(b)) ?
                                        edge_mask : frame_q[b*BEAT_W +: BEAT_W];
        end
      end else begin
        beat_idx_d = beat_idx_q;
      end
      // in_ready is low in COMMIT, so accept and commit never coincide.
      if (commit_s) begin
        acc_d   = merge_f(mode_s, acc_q, frame_q);
        frame_d = '0;
        cnt_d   = cnt_q + FRAME_CNT_W'(1);
      end else begin
        acc_d   = acc_q;
      end
    end
    rdy_d = (state_d != COMMIT);
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b1;
      beat_idx_q <= '0;
      frame_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      beat_idx_q <= beat_idx_d;
      frame_q    <= frame_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  edge_word_mux #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS)
  ) u_rd_mux (
    .clk_i      (CLK),
    .rst_i      (RST),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .data_i     (acc_q),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid)
  );

endmodule

// File: tb/tb_edge_accum_v2_0.sv
// ---------------------------------------------------------------------------
// tb_edge_accum_v2_0
// Self-checking bench for edge_accum_v2_0: reset values, table-driven first
// frame and readback, OR/AND/overwrite merges, clr during COMMIT, read in
// COMMIT, continuous streaming, randomized frames against a frame-level
// model, and a WORD_W=96 instance for the out-of-range read.
// ---------------------------------------------------------------------------
module tb_edge_accum_v2_0;

  localparam int BEAT_W   = 128;
  localparam int BEATS    = 16;
  localparam int WORD_W   = 32;
  localparam int TOTAL_W  = BEAT_W * BEATS;
  localparam int WORDS    = TOTAL_W / WORD_W;
  localparam int V_BEAT_W = 126;
  localparam int V_WORD_W = 96;
  localparam int V_TOTAL  = V_BEAT_W * BEATS;

  logic              CLK = 1'b0;
  logic              RST, clr, in_valid, in_ready, frame_done, rd_en, rd_valid;
  logic [BEAT_W-1:0] edge_mask;
  logic [3:0]        beat_idx;
  logic [15:0]       frame_cnt;
  logic [5:0]        rd_addr;
  logic [31:0]       rd_data;
`ifdef EDGE_ACC_MODE_EN
  logic [1:0]        mode;
  logic [1:0]        v_mode;
`endif

  logic                v_clr, v_in_valid, v_in_ready, v_done, v_rd_en, v_rd_valid;
  logic [V_BEAT_W-1:0] v_mask;
  logic [3:0]          v_beat_idx;
  logic [15:0]         v_cnt;
  logic [4:0]          v_rd_addr;
  logic [V_WORD_W-1:0] v_rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference model.
  logic [TOTAL_W-1:0] m_acc;
  int                 m_cnt;
  logic [BEAT_W-1:0]  fb [BEATS];
  logic [V_TOTAL-1:0] v_acc;

  typedef struct {
    int          addr;
    logic [31:0] exp;
  } rvec_t;
  rvec_t rt [8];

  always #5 CLK = ~CLK;

  edge_accum_v2_0 #(.BEAT_W(BEAT_W), .BEATS(BEATS), .WORD_W(WORD_W)) u_dut (
    .CLK(CLK), .RST(RST), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .edge_mask(edge_mask),
`ifdef EDGE_ACC_MODE_EN
    .mode(mode),
`endif
    .beat_idx(beat_idx), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  edge_accum_v2_0 #(.BEAT_W(V_BEAT_W), .BEATS(BEATS), .WORD_W(V_WORD_W)) u_dut96 (
    .CLK(CLK), .RST(RST), .clr(v_clr), .in_valid(v_in_valid), .in_ready(v_in_ready),
    .edge_mask(v_mask),
`ifdef EDGE_ACC_MODE_EN
    .mode(v_mode),
`endif
    .beat_idx(v_beat_idx), .frame_done(v_done), .frame_cnt(v_cnt),
    .rd_en(v_rd_en), .rd_addr(v_rd_addr), .rd_data(v_rd_data), .rd_valid(v_rd_valid)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_fb();
    for (int k = 0; k < BEATS; k++) fb[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic model_merge(input int m);
    logic [TOTAL_W-1:0] f;
    for (int k = 0; k < BEATS; k++) f[k*BEAT_W +: BEAT_W] = fb[k];
    case (m)
      1:       m_acc = m_acc & f;
      2:       m_acc = f;
      default: m_acc = m_acc | f;
    endcase
    m_cnt = (m_cnt + 1) % 65536;
  endtask

  // Presents fb[0..BEATS-1]; returns at +1 after the last accept (COMMIT cycle).
  task automatic send_beats(input int max_gap);
    for (int k = 0; k < BEATS; k++) begin
      int t;
      t = 0;
      in_valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) cyc();
      in_valid  = 1'b1;
      edge_mask = fb[k];
      #1;
      while (!in_ready && t < 40) begin
        cyc();
        #1;
        t++;
      end
      if (t >= 40) chk("ready_timeout", 128'd0, 128'd1);
      chk("beat_idx", beat_idx, k);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input int m);
    #1;
    chk("frame_done", frame_done, 1);
    chk("commit_ready", in_ready, 0);
    model_merge(m);
    cyc();
    chk("done_pulse_end", frame_done, 0);
    chk("frame_cnt", frame_cnt, m_cnt);
  endtask

  task automatic send_frame(input int m, input int max_gap);
`ifdef EDGE_ACC_MODE_EN
    mode = 2'(m);
`endif
    send_beats(max_gap);
    finish_frame(m);
  endtask

  task automatic rd_chk(input int addr, input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = 6'(addr);
    cyc();
    rd_en = 1'b0;
    chk("rd_valid", rd_valid, 1);
    chk("rd_data", rd_data, exp);
  endtask

  task automatic rd_model(input int addr);
    rd_chk(addr, m_acc[addr*WORD_W +: WORD_W]);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    #1;
    chk("clr_ready", in_ready, 0);
    cyc();
    clr   = 1'b0;
    m_acc = '0;
    m_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [TOTAL_W-1:0] old_acc;
    logic [127:0]       tmp;
    int                 nb;
    int                 m;

    RST = 1'b1; clr = 1'b0; in_valid = 1'b0; edge_mask = '0; rd_en = 1'b0; rd_addr = '0;
    v_clr = 1'b0; v_in_valid = 1'b0; v_mask = '0; v_rd_en = 1'b0; v_rd_addr = '0;
`ifdef EDGE_ACC_MODE_EN
    mode = 2'd0; v_mode = 2'd0;
`endif
    m_acc = '0; m_cnt = 0; v_acc = '0;
    cyc();
    cyc();

    // Reset values
    chk("rst_in_ready", in_ready, 0);
    chk("rst_beat_idx", beat_idx, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    RST = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // Frame with beat k = k, OR mode; table of expected readback words
    for (int k = 0; k < BEATS; k++) fb[k] = 128'(k);
    rt[0] = '{0, 32'd0};  rt[1] = '{4, 32'd1};  rt[2] = '{8, 32'd2};
    rt[3] = '{32, 32'd8}; rt[4] = '{60, 32'd15}; rt[5] = '{63, 32'd0};
    rt[6] = '{1, 32'd0};  rt[7] = '{62, 32'd0};
    send_frame(0, 0);
    for (int i = 0; i < 8; i++) rd_chk(rt[i].addr, rt[i].exp);
    cyc();
    chk("rd_valid_idle", rd_valid, 0);

    // clr, then 0x0F.. | 0xF0.. gives all ones
    do_clr();
    chk("clr_frame_cnt", frame_cnt, 0);
    chk("clr_beat_idx", beat_idx, 0);
    rd_chk(4, 32'd0);
    for (int k = 0; k < BEATS; k++) fb[k] = {16{8'h0F}};
    send_frame(0, 0);
    for (int k = 0; k < BEATS; k++) fb[k] = {16{8'hF0}};
    send_frame(0, 2);
    chk("two_frame_cnt", frame_cnt, 2);
    for (int w = 0; w < WORDS; w++) rd_chk(w, 32'hFFFF_FFFF);

`ifdef EDGE_ACC_MODE_EN
    // AND with beat 0 zero, then overwrite, then reserved mode acting as OR
    fb[0] = '0;
    for (int k = 1; k < BEATS; k++) fb[k] = '1;
    send_frame(1, 0);
    for (int w = 0; w < 8; w++) rd_chk(w, (w < 4) ? 32'd0 : 32'hFFFF_FFFF);
    rand_fb();
    send_frame(2, 1);
    for (int w = 0; w < WORDS; w++) rd_model(w);
    rand_fb();
    send_frame(3, 0);
    for (int w = 0; w < 8; w++) rd_model(w * 9);
`endif

    // Read issued in the COMMIT cycle returns the pre-merge word
    rand_fb();
    old_acc = m_acc;
`ifdef EDGE_ACC_MODE_EN
    mode = 2'd0;
`endif
    send_beats(0);
    rd_en   = 1'b1;
    rd_addr = 6'd63;
    #1;
    chk("commit_done_rd", frame_done, 1);
    cyc();
    rd_en = 1'b0;
    chk("commit_rd_valid", rd_valid, 1);
    chk("commit_rd_old", rd_data, old_acc[63*WORD_W +: WORD_W]);
    model_merge(0);
    chk("commit_rd_cnt", frame_cnt, m_cnt);
    rd_model(63);

    // clr in the COMMIT cycle aborts the merge; beat in clr cycle refused
    rand_fb();
    send_beats(0);
    clr       = 1'b1;
    in_valid  = 1'b1;
    edge_mask = 128'hAB;
    #1;
    chk("abort_done", frame_done, 0);
    chk("abort_ready", in_ready, 0);
    cyc();
    clr = 1'b0;
    in_valid = 1'b0;
    m_acc = '0;
    m_cnt = 0;
    chk("abort_cnt", frame_cnt, 0);
    chk("abort_idx", beat_idx, 0);
    chk("abort_no_pulse", frame_done, 0);
    rd_model(0);
    rd_model(63);
    in_valid = 1'b1;
    #1;
    chk("after_abort_ready", in_ready, 1);
    chk("after_abort_idx0", beat_idx, 0);
    cyc();
    in_valid = 1'b0;
    chk("after_abort_idx1", beat_idx, 1);
    do_clr();

    // Continuous in_valid for 48 beats: one bubble after every 16th beat
`ifdef EDGE_ACC_MODE_EN
    mode = 2'd0;
`endif
    nb = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 3 * (BEATS + 1); c++) begin
      edge_mask = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("stream_ready", in_ready, (c % 17) != 16);
      chk("stream_done", frame_done, (c % 17) == 16);
      if ((c % 17) != 16) begin
        fb[nb % BEATS] = edge_mask;
        nb++;
      end else begin
        model_merge(0);
      end
      cyc();
    end
    in_valid = 1'b0;
    chk("stream_cnt", frame_cnt, 3);
    for (int i = 0; i < 6; i++) rd_model($urandom_range(63, 0));

    // Randomized frames with gaps and random modes
    for (int f = 0; f < 4; f++) begin
`ifdef EDGE_ACC_MODE_EN
      m = $urandom_range(3, 0);
`else
      m = 0;
`endif
      rand_fb();
      send_frame(m, 3);
      for (int i = 0; i < 4; i++) rd_model($urandom_range(63, 0));
    end

    // WORD_W=96 instance: WORDS=21, out-of-range address reads 0 with valid
    v_in_valid = 1'b1;
    for (int k = 0; k < BEATS; k++) begin
      tmp    = {$urandom, $urandom, $urandom, $urandom};
      v_mask = tmp[V_BEAT_W-1:0];
      v_acc[k*V_BEAT_W +: V_BEAT_W] = v_mask;
      #1;
      chk("w96_ready", v_in_ready, 1);
      chk("w96_idx", v_beat_idx, k);
      cyc();
    end
    v_in_valid = 1'b0;
    #1;
    chk("w96_done", v_done, 1);
    cyc();
    chk("w96_cnt", v_cnt, 1);
    v_rd_en = 1'b1;
    v_rd_addr = 5'd20;
    cyc();
    chk("w96_rd20_valid", v_rd_valid, 1);
    chk("w96_rd20", v_rd_data, v_acc[20*V_WORD_W +: V_WORD_W]);
    v_rd_addr = 5'd25;
    cyc();
    chk("w96_rd25_valid", v_rd_valid, 1);
    chk("w96_rd25", v_rd_data, 0);
    v_rd_addr = 5'd0;
    cyc();
    v_rd_en = 1'b0;
    chk("w96_rd0", v_rd_data, v_acc[0 +: V_WORD_W]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
